fa_anneal_sched: RTL and testbench



---
 rtl/fa_anneal_sched_pkg.sv | 62 ++++++
 rtl/fa_anneal_sched_if.sv | 22 ++
 rtl/fa_anneal_sched_tally.sv | 34 +++
 rtl/fa_anneal_sched.sv | 146 ++++++++++++++
 tb/tb_fa_anneal_sched.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/fa_anneal_sched_pkg.sv
// Shared types for the full-adder p-bit scheduler: FSM states, job modes, clamp encoding.
// Latency: none (types and a pure combinational helper only).
// Backpressure: n/a.
package fa_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        ANNEAL,
        SAMPLE,
        DONE
    } state_t;

    localparam logic [1:0] MODE_FWD  = 2'd0;
    localparam logic [1:0] MODE_INV  = 2'd1;
    localparam logic [1:0] MODE_SUB  = 2'd2;
    localparam logic [1:0] MODE_FREE = 2'd3;

    // bit1 = clamped, bit0 = clamp value
    localparam logic [1:0] CLAMP_FREE = 2'b00;
    localparam logic [1:0] CLAMP_0    = 2'b10;
    localparam logic [1:0] CLAMP_1    = 2'b11;

    // Field order matches the network bit order {cout,s,cin,b,a}, so the
    // packed struct can be indexed as a flat vector with bit i at [2i+1:2i].
    typedef struct packed {
        logic [1:0] cout;
        logic [1:0] s;
        logic [1:0] cin;
        logic [1:0] b;
        logic [1:0] a;
    } clamp_t;

    function automatic logic [1:0] clamp_of(input logic v);
        return v ? CLAMP_1 : CLAMP_0;
    endfunction

    // Which network nodes are pinned, and to what, for each job mode.
    function automatic clamp_t clamp_map(input logic [1:0] mode, input logic [2:0] bits);
        clamp_t c;
        c = '0;
        case (mode)
            MODE_FWD: begin
                c.a   = clamp_of(bits[2]);
                c.b   = clamp_of(bits[1]);
                c.cin = clamp_of(bits[0]);
            end
            MODE_INV: begin
                c.s    = clamp_of(bits[2]);
                c.cout = clamp_of(bits[1]);
            end
            MODE_SUB: begin
                c.a   = clamp_of(bits[2]);
                c.s   = clamp_of(bits[1]);
                c.cin = clamp_of(bits[0]);
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/fa_anneal_sched_if.sv
// Job request and result return handshakes between host and scheduler.
// Latency: none (wiring only).
// Backpressure: valid/ready on both the job and the result channel.
interface fa_anneal_sched_if;
    logic       job_valid;
    logic       job_ready;
    logic [1:0] job_mode;
    logic [2:0] job_bits;
    logic       res_valid;
    logic       res_ready;
    logic [4:0] res_bits;

    modport master (
        output job_valid, job_mode, job_bits, res_ready,
        input  job_ready, res_valid, res_bits
    );

    modport slave (
        input  job_valid, job_mode, job_bits, res_ready,
        output job_ready, res_valid, res_bits
    );
endinterface

// File: rtl/fa_anneal_sched_tally.sv
// Five per-p-bit ones counters with clear/enable and a strict-majority output.
// Latency: counts update on the enabled edge; majority is combinational from the counts.
// Backpressure: none; the caller gates en for exactly the sample window.
module pbit_tally #(
    parameter int N_SAMPLES = 1024
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       en,
    input  logic [4:0] bits,
    output logic [4:0] maj
);
    localparam int TW = $clog2(N_SAMPLES + 1);
    // 2*count needs one extra bit; compare against N at that width.
    localparam logic [TW:0] N_X = (TW + 1)'(N_SAMPLES);

    logic [TW-1:0] cnt [5];

    // Accumulate ones while enabled; clearing wins over counting.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            for (int i = 0; i < 5; i++) cnt[i] <= '0;
        end else if (en) begin
            for (int i = 0; i < 5; i++) cnt[i] <= cnt[i] + TW'(bits[i]);
        end
    end

    // Majority is strict: exactly half ones resolves to 0.
    always_comb begin
        maj = '0;
        for (int i = 0; i < 5; i++) maj[i] = {cnt[i], 1'b0} > N_X;
    end
endmodule

// File: rtl/fa_anneal_sched.sv
// Runs one full-adder p-bit job: clamp, settle in reset, anneal I_0 (FA_SCHED_ANNEAL_EN), sample, vote.
// Latency: SETTLE_CYCLES + anneal + N_SAMPLES + 1 cycles from job acceptance to res_valid.
// Backpressure: one job at a time; job_ready only in IDLE, result held until res_ready.
module fa_anneal_sched
    import fa_sched_pkg::*;
#(
    parameter logic [3:0] I0_START      = 4'd1,
    parameter logic [3:0] I0_END        = 4'd4,
    parameter int         STEP_CYCLES   = 256,
    parameter int         N_SAMPLES     = 1024,
    parameter int         SETTLE_CYCLES = 2
) (
    input  logic               clk,
    input  logic               reset,
    fa_anneal_sched_if.slave   bus,
    output logic               fa_reset,
    output logic               fa_update_mode,
    output logic [3:0]         fa_i0,
    output logic [1:0]         a_clamp,
    output logic [1:0]         b_clamp,
    output logic [1:0]         cin_clamp,
    output logic [1:0]         s_clamp,
    output logic [1:0]         cout_clamp,
    input  logic [4:0]         fa_p_bits
);
    localparam int CMAX0 = (N_SAMPLES > STEP_CYCLES) ? N_SAMPLES : STEP_CYCLES;
    localparam int CMAX  = (CMAX0 > SETTLE_CYCLES) ? CMAX0 : SETTLE_CYCLES;
    localparam int CW    = $clog2(CMAX + 1);

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [3:0]    i0_nxt;
    clamp_t        clamp, clamp_nxt;
    logic [9:0]    clamp_vec;
    logic [4:0]    maj;
    logic [4:0]    res;
    logic          accept;

    assign bus.job_ready = (state == IDLE);
    assign accept        = bus.job_valid && bus.job_ready;

    // State, phase counter, temperature and clamp registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            fa_i0 <= I0_START;
            clamp <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            fa_i0 <= i0_nxt;
            clamp <= clamp_nxt;
        end
    end

    // Phase sequencing; one shared counter times whichever phase is active.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        i0_nxt    = fa_i0;
        clamp_nxt = clamp;
        case (state)
            IDLE: begin
                cnt_nxt   = '0;
                i0_nxt    = I0_START;
                clamp_nxt = '0;
                if (accept) begin
                    state_nxt = SETTLE;
                    clamp_nxt = clamp_map(bus.job_mode, bus.job_bits);
`ifdef FA_SCHED_ANNEAL_EN
                    i0_nxt    = I0_START;
`else
                    i0_nxt    = I0_END;
`endif
                end
            end
            SETTLE: begin
                if (cnt == CW'(SETTLE_CYCLES - 1)) begin
                    cnt_nxt   = '0;
`ifdef FA_SCHED_ANNEAL_EN
                    state_nxt = ANNEAL;
`else
                    state_nxt = SAMPLE;
`endif
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            ANNEAL: begin
                // >= rather than == so a start above the end still leaves after one step.
                if (cnt == CW'(STEP_CYCLES - 1)) begin
                    cnt_nxt = '0;
                    if (fa_i0 >= I0_END) state_nxt = SAMPLE;
                    else                 i0_nxt    = fa_i0 + 4'd1;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            SAMPLE: begin
                if (cnt == CW'(N_SAMPLES - 1)) begin
                    cnt_nxt   = '0;
                    state_nxt = DONE;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            DONE: begin
                if (bus.res_ready) begin
                    state_nxt = IDLE;
                    clamp_nxt = '0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    pbit_tally #(.N_SAMPLES(N_SAMPLES)) u_tally (
        .clk   (clk),
        .reset (reset),
        .clr   (state == IDLE),
        .en    (state == SAMPLE),
        .bits  (fa_p_bits),
        .maj   (maj)
    );

    assign clamp_vec = clamp;

    // Result: vote per bit, but a clamped node reports its clamp value.
    always_comb begin
        res = '0;
        if (state == DONE) begin
            for (int i = 0; i < 5; i++) res[i] = clamp_vec[2*i+1] ? clamp_vec[2*i] : maj[i];
        end
    end

    assign bus.res_valid  = (state == DONE);
    assign bus.res_bits   = res;
    assign fa_reset       = (state == IDLE) || (state == SETTLE);
    assign fa_update_mode = 1'b0;
    assign a_clamp        = clamp.a;
    assign b_clamp        = clamp.b;
    assign cin_clamp      = clamp.cin;
    assign s_clamp        = clamp.s;
    assign cout_clamp     = clamp.cout;
endmodule

// File: tb/tb_fa_anneal_sched.sv
// Directed bench for fa_anneal_sched with a stub network driving per-bit ones counts.
// Latency: checks acceptance-to-result latency and the I_0 / fa_reset sequence per job.
// Backpressure: holds res_ready low with a competing job request pending.
`timescale 1ns/1ps
module tb_fa_anneal_sched;
    import fa_sched_pkg::*;

    localparam int         S    = 2;
    localparam int         STEP = 256;
    localparam int         N    = 1024;
    localparam logic [3:0] I0S  = 4'd1;
    localparam logic [3:0] I0E  = 4'd4;
`ifdef FA_SCHED_ANNEAL_EN
    localparam bit ANN = 1'b1;
    localparam int A   = (((I0E > I0S) ? (int'(I0E) - int'(I0S)) : 0) + 1) * STEP;
`else
    localparam bit ANN = 1'b0;
    localparam int A   = 0;
`endif

    logic       clk;
    logic       reset;
    logic       fa_reset, fa_update_mode;
    logic [3:0] fa_i0;
    logic [1:0] a_clamp, b_clamp, cin_clamp, s_clamp, cout_clamp;
    logic [4:0] fa_p_bits;

    fa_anneal_sched_if bus ();

    fa_anneal_sched #(
        .I0_START(I0S), .I0_END(I0E), .STEP_CYCLES(STEP),
        .N_SAMPLES(N), .SETTLE_CYCLES(S)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .fa_reset(fa_reset), .fa_update_mode(fa_update_mode), .fa_i0(fa_i0),
        .a_clamp(a_clamp), .b_clamp(b_clamp), .cin_clamp(cin_clamp),
        .s_clamp(s_clamp), .cout_clamp(cout_clamp), .fa_p_bits(fa_p_bits)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ones[i]: number of leading sample-window cycles on which bit i is 1.
    typedef struct packed {
        logic [1:0]       mode;
        logic [2:0]       bits;
        logic [4:0][10:0] ones;      // [4]=cout .. [0]=a
        logic [9:0]       exp_clamp; // {cout,s,cin,b,a}
        logic [4:0]       exp_res;   // {cout,s,cin,b,a}
    } vec_t;

    vec_t tv [5];

    function automatic logic [9:0] clamps_now();
        return {cout_clamp, s_clamp, cin_clamp, b_clamp, a_clamp};
    endfunction

    // Outside the sample window every bit reads 1, so stray sampling shows up.
    function automatic logic [4:0] stub(input int n, input logic [4:0][10:0] ones);
        int idx;
        logic [4:0] r;
        idx = n - (S + A + 1);
        for (int i = 0; i < 5; i++)
            r[i] = (idx < 0 || idx >= N) ? 1'b1 : (idx < int'(ones[i]));
        return r;
    endfunction

    function automatic logic [3:0] exp_i0_at(input int n);
        int t;
        if (!ANN) return I0E;
        if (n <= S) return I0S;
        t = int'(I0S) + (n - S - 1) / STEP;
        if (t > int'(I0E) || n > S + A) t = int'(I0E);
        return 4'(t);
    endfunction

    task automatic run_job(input vec_t v, input int hold);
        int   n, lat;
        bit   seq_ok, stable;
        logic [4:0] snap;
        check("job_ready_before", 32'(bus.job_ready), 32'd1);
        bus.job_valid = 1'b1;
        bus.job_mode  = v.mode;
        bus.job_bits  = v.bits;
        fa_p_bits     = 5'h1f;
        tick();
        bus.job_valid = 1'b0;
        check("clamps", 32'(clamps_now()), 32'(v.exp_clamp));
        check("job_ready_busy", 32'(bus.job_ready), 32'd0);
        n = 1; lat = 0; seq_ok = 1'b1;
        while (lat == 0 && n < S + A + N + 100) begin
            fa_p_bits = stub(n, v.ones);
            if (bus.res_valid) begin
                lat = n;
            end else begin
                if (seq_ok && (fa_i0 !== exp_i0_at(n) || fa_reset !== (n <= S))) begin
                    seq_ok = 1'b0;
                    $display("note: first i0/reset deviation at cycle %0d: i0=%0d reset=%0b",
                             n, fa_i0, fa_reset);
                end
                tick();
                n++;
            end
        end
        check("i0_reset_seq", 32'(seq_ok), 32'd1);
        check("latency", 32'(lat), 32'(S + A + N + 1));
        check("res_bits", 32'(bus.res_bits), 32'(v.exp_res));
        snap = bus.res_bits;
        // Hold the result while a competing job is offered; it must be ignored.
        bus.job_valid = 1'b1;
        bus.job_mode  = MODE_FREE;
        bus.job_bits  = 3'b000;
        stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
            tick();
            if (bus.res_valid !== 1'b1 || bus.res_bits !== snap || bus.job_ready !== 1'b0 ||
                clamps_now() !== v.exp_clamp || fa_i0 !== I0E)
                stable = 1'b0;
        end
        check("hold_stable", 32'(stable), 32'd1);
        bus.job_valid = 1'b0;
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
        check("idle_job_ready", 32'(bus.job_ready), 32'd1);
        check("idle_res_valid", 32'(bus.res_valid), 32'd0);
        check("idle_clamps", 32'(clamps_now()), 32'd0);
        check("idle_fa_reset", 32'(fa_reset), 32'd1);
    endtask

    initial begin
        // Forward 110: a=1,b=1,cin=0 clamped; cout mostly 1, s never.
        tv[0].mode = MODE_FWD; tv[0].bits = 3'b110;
        tv[0].ones = {11'd717, 11'd0, 11'd0, 11'd0, 11'd0};
        tv[0].exp_clamp = {CLAMP_FREE, CLAMP_FREE, CLAMP_0, CLAMP_1, CLAMP_1};
        tv[0].exp_res = 5'b10011;
        // Inverse 01x: s=0, cout=1 forced despite opposite stub activity.
        tv[1].mode = MODE_INV; tv[1].bits = 3'b011;
        tv[1].ones = {11'd0, 11'd1024, 11'd600, 11'd600, 11'd600};
        tv[1].exp_clamp = {CLAMP_1, CLAMP_0, CLAMP_FREE, CLAMP_FREE, CLAMP_FREE};
        tv[1].exp_res = 5'b10111;
        // Subtract 101: b exactly half (tie -> 0), cout one above half.
        tv[2].mode = MODE_SUB; tv[2].bits = 3'b101;
        tv[2].ones = {11'd513, 11'd1024, 11'd0, 11'd512, 11'd0};
        tv[2].exp_clamp = {CLAMP_FREE, CLAMP_0, CLAMP_1, CLAMP_FREE, CLAMP_1};
        tv[2].exp_res = 5'b10101;
        // Free-run: job_bits ignored, pure vote.
        tv[3].mode = MODE_FREE; tv[3].bits = 3'b111;
        tv[3].ones = {11'd1, 11'd0, 11'd512, 11'd513, 11'd1024};
        tv[3].exp_clamp = 10'd0;
        tv[3].exp_res = 5'b00011;
        // Forward 001.
        tv[4].mode = MODE_FWD; tv[4].bits = 3'b001;
        tv[4].ones = {11'd300, 11'd700, 11'd0, 11'd1024, 11'd1024};
        tv[4].exp_clamp = {CLAMP_FREE, CLAMP_FREE, CLAMP_1, CLAMP_0, CLAMP_0};
        tv[4].exp_res = 5'b01100;

        reset = 1'b1;
        bus.job_valid = 1'b0; bus.job_mode = 2'd0; bus.job_bits = 3'd0;
        bus.res_ready = 1'b0;
        fa_p_bits = 5'h1f;
        repeat (3) tick();
        check("rst_job_ready", 32'(bus.job_ready), 32'd1);
        check("rst_fa_reset", 32'(fa_reset), 32'd1);
        check("rst_fa_i0", 32'(fa_i0), 32'(I0S));
        check("rst_clamps", 32'(clamps_now()), 32'd0);
        check("rst_res_valid", 32'(bus.res_valid), 32'd0);
        check("rst_res_bits", 32'(bus.res_bits), 32'd0);
        check("rst_update_mode", 32'(fa_update_mode), 32'd0);
        reset = 1'b0;
        tick();

        for (int k = 0; k < 5; k++) run_job(tv[k], (k == 0) ? 50 : 2);

        // Abort a job mid-sample, then confirm a following job sees no stale counts.
        bus.job_valid = 1'b1; bus.job_mode = tv[2].mode; bus.job_bits = tv[2].bits;
        tick();
        bus.job_valid = 1'b0;
        for (int n = 1; n < S + A + 40; n++) begin
            fa_p_bits = 5'h1f;
            tick();
        end
        reset = 1'b1;
        tick();
        check("abort_clamps", 32'(clamps_now()), 32'd0);
        check("abort_fa_reset", 32'(fa_reset), 32'd1);
        check("abort_res_valid", 32'(bus.res_valid), 32'd0);
        check("abort_job_ready", 32'(bus.job_ready), 32'd1);
        check("abort_fa_i0", 32'(fa_i0), 32'(I0S));
        reset = 1'b0;
        tick();
        run_job(tv[2], 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
